// File: rtl/tlb_op_sequencer.sv
// Serializes TLB maintenance ops: drain older instructions, run one TLB port transaction, write CSRs, flush and refetch.
// Optional feature macro: TLB_INVTLB_EN (INVTLB sequenced when defined, otherwise op_kind 4 is reserved).
module tlb_op_sequencer #(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_kind,
  input  logic [31:0]      op_pc,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [31:0]      inv_va,
  input  logic             pipe_empty,
  input  logic             cancel,
  input  logic [IDX_W-1:0] csr_tlbidx_idx,
  output logic             tlb_req,
  output logic [2:0]       tlb_cmd,
  output logic [IDX_W-1:0] tlb_idx,
  output logic [4:0]       tlb_inv_op,
  output logic [9:0]       tlb_inv_asid,
  output logic [31:0]      tlb_inv_va,
  input  logic             tlb_ack,
  input  logic             tlb_hit,
  input  logic [IDX_W-1:0] tlb_hit_idx,
  output logic             csr_we,
  output logic             csr_ne,
  output logic             csr_idx_we,
  output logic [IDX_W-1:0] csr_idx,
  output logic             csr_load_entry,
  output logic             csr_clear_entry,
  output logic             flush_req,
  output logic [31:0]      refetch_pc,
  output logic             ine,
  output logic             busy
);

  localparam logic [2:0] K_SRCH = 3'd0;
  localparam logic [2:0] K_RD   = 3'd1;
  localparam logic [2:0] K_WR   = 3'd2;
  localparam logic [2:0] K_FILL = 3'd3;
  localparam logic [2:0] K_INV  = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ISSUE, S_WB, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] fill_cnt;
  logic             ill_q;
  logic             accept, legal;
  logic [IDX_W-1:0] idx_sel;

  logic [2:0]       kind_p0;
  logic [31:0]      pc_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             hit_p1;
  logic [IDX_W-1:0] hit_idx_p1;

  function automatic logic kind_legal(input logic [2:0] k);
`ifdef TLB_INVTLB_EN
    return k <= K_INV;
`else
    return k < K_INV;
`endif
  endfunction

  assign accept = (state_q == S_IDLE) && op_valid;
  assign legal  = kind_legal(op_kind);

  always_comb begin
    idx_sel = '0;
    if (op_kind == K_FILL)                        idx_sel = fill_cnt;
    else if ((op_kind == K_RD) || (op_kind == K_WR)) idx_sel = csr_tlbidx_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fill_cnt <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_cnt <= (fill_cnt == IDX_W'(TLB_NUM - 1)) ? '0 : fill_cnt + 1'b1;
      ill_q    <= accept && !legal;
    end
  end

  // p0: operation fields captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_p0 <= op_kind;
      pc_p0   <= op_pc;
      idx_p0  <= idx_sel;
    end
  end

  // p1: TLB response captured on the ack cycle for the writeback cycle
  always_ff @(posedge clk) begin
    if ((state_q == S_ISSUE) && tlb_ack) begin
      hit_p1     <= tlb_hit;
      hit_idx_p1 <= tlb_hit_idx;
    end
  end

`ifdef TLB_INVTLB_EN
  logic [4:0]  inv_op_p0;
  logic [9:0]  inv_asid_p0;
  logic [31:0] inv_va_p0;

  always_ff @(posedge clk) begin
    if (accept) begin
      inv_op_p0   <= inv_op;
      inv_asid_p0 <= inv_asid;
      inv_va_p0   <= inv_va;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = ^{inv_op, inv_asid, inv_va};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && legal) state_d = S_DRAIN;
      S_DRAIN: begin
        // cancel outranks pipe_empty so a squashed op never reaches the TLB
        if (cancel)          state_d = S_IDLE;
        else if (pipe_empty) state_d = S_ISSUE;
      end
      S_ISSUE: if (tlb_ack) state_d = S_WB;
      S_WB:    state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready        = rst_n && (state_q == S_IDLE);
    busy            = (state_q != S_IDLE);
    tlb_req         = 1'b0;
    tlb_cmd         = '0;
    tlb_idx         = '0;
    tlb_inv_op      = '0;
    tlb_inv_asid    = '0;
    tlb_inv_va      = '0;
    csr_we          = 1'b0;
    csr_ne          = 1'b0;
    csr_idx_we      = 1'b0;
    csr_idx         = '0;
    csr_load_entry  = 1'b0;
    csr_clear_entry = 1'b0;
    flush_req       = 1'b0;
    refetch_pc      = '0;
    ine             = 1'b0;
    case (state_q)
      S_IDLE: begin
        // reserved op: refetch the offending instruction itself
        if (ill_q) begin
          ine        = 1'b1;
          flush_req  = 1'b1;
          refetch_pc = pc_p0;
        end
      end
      S_ISSUE: begin
        tlb_req = 1'b1;
        tlb_cmd = kind_p0;
        tlb_idx = idx_p0;
`ifdef TLB_INVTLB_EN
        if (kind_p0 == K_INV) begin
          tlb_inv_op   = inv_op_p0;
          tlb_inv_asid = inv_asid_p0;
          tlb_inv_va   = inv_va_p0;
        end
`endif
      end
      S_WB: begin
        if (kind_p0 == K_SRCH) begin
          csr_we     = 1'b1;
          csr_ne     = !hit_p1;
          csr_idx_we = hit_p1;
          csr_idx    = hit_p1 ? hit_idx_p1 : '0;
        end else if (kind_p0 == K_RD) begin
          csr_we          = 1'b1;
          csr_ne          = !hit_p1;
          csr_load_entry  = hit_p1;
          csr_clear_entry = !hit_p1;
        end
      end
      S_FLUSH: begin
        flush_req  = 1'b1;
        refetch_pc = pc_p0 + 32'd4;
      end
      default: ;
    endcase
  end

endmodule
